intr_ctrl: RTL and testbench



---
 rtl/intr_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_intr_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
//
// Multi-source interrupt controller that sits between the external interrupt
// sources and the fetch/decode stages of the pipelined core. Each source has
// rising-edge capture, a pending latch, a mask bit and a sticky overrun flag.
// One eligible source at a time is dispatched. Its ID and data word are
// latched for the RDI path, and a request is held to fetch until it is
// acknowledged. The FSM then waits in SERVICE until the handler returns.
//
// Optional feature (compile-time macro INTC_ROUND_ROBIN_EN):
//   defined   : round-robin arbitration. The search starts at rr_ptr.
//   undefined : fixed priority, and the lowest index wins. No pointer logic
//               is built.
//
// Handshake: irq_req stays high for every cycle the FSM is in REQ. A cycle
// with irq_req=1 and irq_ack=1 is the transfer, and irq_req is low in the
// following cycle. A one-cycle irq_done pulse while in SERVICE ends service.
// irq_ack is ignored outside REQ, and irq_done is ignored outside SERVICE.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   irq_in       in   [NUM_SRC]         raw level-high interrupt lines
//   src_data     in   [NUM_SRC*DATA_W]  per-source data, slice i at i*DATA_W
//   mask_we      in   mask write strobe
//   mask_wdata   in   [NUM_SRC]         new mask value (1 = enabled)
//   ovr_clr      in   clears all overrun flags
//   irq_ack      in   fetch accepted the request
//   irq_done     in   handler return (RTI/RSI)
//   irq_req      out  request to fetch
//   busy         out  request outstanding or handler in service
//   active_id    out  [ID_W]    ID of the source being serviced
//   active_data  out  [DATA_W]  data captured from the active source
//   pending      out  [NUM_SRC] pending flags
//   overrun      out  [NUM_SRC] sticky overrun flags
//   mask         out  [NUM_SRC] current mask
// ---------------------------------------------------------------------------
module intr_ctrl #(
    parameter int                 NUM_SRC  = 4,
    parameter int                 DATA_W   = 32,
    parameter logic [NUM_SRC-1:0] MASK_RST = {NUM_SRC{1'b1}},
    localparam int                ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         irq_in,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    input  logic                       mask_we,
    input  logic [NUM_SRC-1:0]         mask_wdata,
    input  logic                       ovr_clr,
    input  logic                       irq_ack,
    input  logic                       irq_done,
    output logic                       irq_req,
    output logic                       busy,
    output logic [ID_W-1:0]            active_id,
    output logic [DATA_W-1:0]          active_data,
    output logic [NUM_SRC-1:0]         pending,
    output logic [NUM_SRC-1:0]         overrun,
    output logic [NUM_SRC-1:0]         mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_SRC-1:0]  r_irq_q;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_overrun;
    logic [NUM_SRC-1:0]  r_mask;
    logic [ID_W-1:0]     r_active_id;
    logic [DATA_W-1:0]   r_active_data;

    logic [NUM_SRC-1:0]  w_rise;
    logic [NUM_SRC-1:0]  w_eligible;
    logic [NUM_SRC-1:0]  w_clr;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_dispatch;
    logic                w_irq_req;
    logic                w_busy;

    assign w_rise     = irq_in & ~r_irq_q;
    assign w_eligible = r_pending & r_mask;

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_rr_ptr;

    // Two descending passes, and each one leaves its lowest hit behind. The
    // second pass only looks at indices at or above rr_ptr and overrides the
    // first. This gives a search that starts at rr_ptr and wraps to 0.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found    = 1'b1;
                w_winner   = ID_W'(i);
                w_win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_winner   = ID_W'(i);
                w_win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_dispatch) begin
            r_rr_ptr <= (w_winner == ID_W'(NUM_SRC - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`else
    // Fixed priority. The loop runs in descending order, so the lowest
    // eligible index is the last one written and wins.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_data = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_found    = 1'b1;
                w_winner   = ID_W'(i);
                w_win_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end
`endif

    // One-hot clear of the dispatched source's pending bit.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = w_dispatch && (w_winner == ID_W'(i));
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found)  w_state_nxt = S_REQ;
            S_REQ:     if (irq_ack)  w_state_nxt = S_SERVICE;
            S_SERVICE: if (irq_done) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_irq_req  = 1'b0;
        w_busy     = 1'b0;
        w_dispatch = 1'b0;
        case (r_state)
            S_IDLE:    w_dispatch = w_found;
            S_REQ: begin
                w_irq_req = 1'b1;
                w_busy    = 1'b1;
            end
            S_SERVICE: w_busy = 1'b1;
            default: begin
                w_irq_req  = 1'b0;
                w_busy     = 1'b0;
                w_dispatch = 1'b0;
            end
        endcase
    end

    // Source bookkeeping. A new edge always wins over the dispatch clear. An
    // edge that arrives while the pending bit is already set, and is not
    // being cleared, merges into that bit and raises overrun. A new overrun
    // also wins over ovr_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q       <= '0;
            r_pending     <= '0;
            r_overrun     <= '0;
            r_mask        <= MASK_RST;
            r_active_id   <= '0;
            r_active_data <= '0;
        end else begin
            r_irq_q   <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= (ovr_clr ? '0 : r_overrun) | (w_rise & r_pending & ~w_clr);
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_dispatch) begin
                r_active_id   <= w_winner;
                r_active_data <= w_win_data;
            end
        end
    end

    assign irq_req     = w_irq_req;
    assign busy        = w_busy;
    assign active_id   = r_active_id;
    assign active_data = r_active_data;
    assign pending     = r_pending;
    assign overrun     = r_overrun;
    assign mask        = r_mask;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
//
// Directed scenarios followed by a randomized run. A behavioural model of the
// controller advances on every clock edge. All outputs are compared with the
// model after each edge. Dispatched data words also pass through an expected
// queue.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam int NUM = 4;
    localparam int DW  = 32;
    localparam int IW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic [NUM-1:0]       irq_in = '0;
    logic [NUM*DW-1:0]    src_data = '0;
    logic                 mask_we = 1'b0;
    logic [NUM-1:0]       mask_wdata = '0;
    logic                 ovr_clr = 1'b0;
    logic                 irq_ack = 1'b0;
    logic                 irq_done = 1'b0;
    logic                 irq_req;
    logic                 busy;
    logic [IW-1:0]        active_id;
    logic [DW-1:0]        active_data;
    logic [NUM-1:0]       pending;
    logic [NUM-1:0]       overrun;
    logic [NUM-1:0]       mask;

    intr_ctrl #(.NUM_SRC(NUM), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .src_data    (src_data),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .ovr_clr     (ovr_clr),
        .irq_ack     (irq_ack),
        .irq_done    (irq_done),
        .irq_req     (irq_req),
        .busy        (busy),
        .active_id   (active_id),
        .active_data (active_data),
        .pending     (pending),
        .overrun     (overrun),
        .mask        (mask)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // The model tracks two flags: whether a request is outstanding, and
    // whether a handler is running.
    bit          m_pend [NUM];
    bit          m_ovr  [NUM];
    bit          m_mask [NUM];
    bit          m_prev [NUM];
    bit          m_waiting_ack;
    bit          m_in_handler;
    int          m_id;
    logic [DW-1:0] m_data;
    int          m_rr;
    bit          m_just_dispatched;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int win;
        bit rise;
        win = -1;
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                m_pend[i] = 0; m_ovr[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
            end
            m_waiting_ack = 0; m_in_handler = 0; m_id = 0; m_data = '0;
            m_rr = 0; m_just_dispatched = 0;
            exp_q.delete();
        end else begin
            if (!m_waiting_ack && !m_in_handler) begin
                for (int k = 0; k < NUM; k++) begin
                    int i;
`ifdef INTC_ROUND_ROBIN_EN
                    i = (m_rr + k) % NUM;
`else
                    i = k;
`endif
                    if (win < 0 && m_pend[i] && m_mask[i]) win = i;
                end
            end
            for (int i = 0; i < NUM; i++) begin
                rise = irq_in[i] && !m_prev[i];
                m_ovr[i]  = (ovr_clr ? 1'b0 : m_ovr[i]) || (rise && m_pend[i] && (i != win));
                m_pend[i] = rise || (m_pend[i] && (i != win));
                m_prev[i] = irq_in[i];
            end
            if (mask_we) for (int i = 0; i < NUM; i++) m_mask[i] = mask_wdata[i];
            m_just_dispatched = (win >= 0);
            if (win >= 0) begin
                m_waiting_ack = 1;
                m_id = win;
                m_data = src_data[win*DW +: DW];
                m_rr = (win + 1) % NUM;
                exp_q.push_back(m_data);
            end else if (m_waiting_ack && irq_ack) begin
                m_waiting_ack = 0;
                m_in_handler = 1;
            end else if (m_in_handler && irq_done) begin
                m_in_handler = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NUM-1:0] e_pend, e_ovr, e_mask;
        for (int i = 0; i < NUM; i++) begin
            e_pend[i] = m_pend[i]; e_ovr[i] = m_ovr[i]; e_mask[i] = m_mask[i];
        end
        check("irq_req", 64'(irq_req), 64'(m_waiting_ack));
        check("busy", 64'(busy), 64'(m_waiting_ack || m_in_handler));
        check("active_id", 64'(active_id), 64'(m_id));
        check("active_data", 64'(active_data), 64'(m_data));
        check("pending", 64'(pending), 64'(e_pend));
        check("overrun", 64'(overrun), 64'(e_ovr));
        check("mask", 64'(mask), 64'(e_mask));
        if (m_just_dispatched && exp_q.size() > 0) begin
            check("dispatch_data", 64'(active_data), 64'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the active edge, so they are stable at
    // the next edge. Outputs are checked at the same point.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_src(input int idx, input logic [DW-1:0] val);
        src_data[idx*DW +: DW] = val;
    endtask

    int exp_first, exp_second;

    initial begin
        // Reset, then 10 idle cycles.
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_irq_req", 64'(irq_req), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_mask", 64'(mask), 64'hF);
            check("idle_pending", 64'(pending), 64'd0);
        end

        // Single source 2 with its data, then ack and done.
        set_src(2, 32'hDEAD_BEEF);
        irq_in = 4'b0100;
        step();
        check("t2_pending2", 64'(pending[2]), 64'd1);
        check("t2_req_early", 64'(irq_req), 64'd0);
        step();
        check("t2_req", 64'(irq_req), 64'd1);
        check("t2_id", 64'(active_id), 64'd2);
        check("t2_data", 64'(active_data), 64'hDEAD_BEEF);
        step();
        irq_done = 1'b1;          // ignored in REQ
        step();
        irq_done = 1'b0;
        check("t2_done_ignored", 64'(irq_req), 64'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t2_ack_req", 64'(irq_req), 64'd0);
        check("t2_ack_busy", 64'(busy), 64'd1);
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        check("t2_done_busy", 64'(busy), 64'd0);
        check("t2_id_held", 64'(active_id), 64'd2);
        irq_in = '0;
        step();

        // Sources 1 and 3 rise together.
`ifdef INTC_ROUND_ROBIN_EN
        exp_first = 3; exp_second = 1;
`else
        exp_first = 1; exp_second = 3;
`endif
        set_src(1, 32'h1111_0001);
        set_src(3, 32'h3333_0003);
        irq_in = 4'b1010;
        step();
        step();
        check("t3_first_id", 64'(active_id), 64'(exp_first));
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_done = 1'b1; step(); irq_done = 1'b0;
        check("t3_bubble_req", 64'(irq_req), 64'd0);
        check("t3_bubble_busy", 64'(busy), 64'd0);
        step();
        check("t3_second_req", 64'(irq_req), 64'd1);
        check("t3_second_id", 64'(active_id), 64'(exp_second));
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_done = 1'b1; step(); irq_done = 1'b0;
        irq_in = '0;
        step();

        // Overrun on source 0 while source 1 is in service.
        irq_in = 4'b0010;
        step(); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_in = 4'b0011; step();
        irq_in = 4'b0010; step();
        irq_in = 4'b0011; step();
        check("t4_pend0", 64'(pending[0]), 64'd1);
        check("t4_ovr0", 64'(overrun[0]), 64'd1);
        check("t4_busy", 64'(busy), 64'd1);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        check("t4_ovr_clr", 64'(overrun), 64'd0);
        irq_done = 1'b1; step(); irq_done = 1'b0;
        step();
        check("t4_src0_req", 64'(irq_req), 64'd1);
        check("t4_src0_id", 64'(active_id), 64'd0);
        check("t4_src0_pend", 64'(pending), 64'd0);
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        irq_done = 1'b1; step(); irq_done = 1'b0;
        step();
        check("t4_once", 64'(irq_req), 64'd0);
        irq_in = '0;
        step();

        // Masking.
        mask_we = 1'b1; mask_wdata = 4'b1110; step(); mask_we = 1'b0;
        check("t5_mask", 64'(mask), 64'hE);
        irq_in = 4'b0001;
        step(); step();
        check("t5_pend0", 64'(pending[0]), 64'd1);
        check("t5_no_req", 64'(irq_req), 64'd0);
        mask_we = 1'b1; mask_wdata = 4'hF; step(); mask_we = 1'b0;
        check("t5_req_wait", 64'(irq_req), 64'd0);
        step();
        check("t5_req", 64'(irq_req), 64'd1);
        check("t5_id", 64'(active_id), 64'd0);

        // Reset while in REQ.
        irq_in = '0;
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_req", 64'(irq_req), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_pending", 64'(pending), 64'd0);
        check("t6_mask", 64'(mask), 64'hF);
        step();

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NUM; b++) begin
                if ($urandom_range(0, 3) == 0) irq_in[b] = ~irq_in[b];
                set_src(b, $urandom());
            end
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_done   = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            ovr_clr    = ($urandom_range(0, 15) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
